// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch/decode definitions: opcodes, instruction field
// positions, fetch FSM state encoding and the default reset PC.
package instr_fetch_unit_pkg;

    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] JUMP  = 6'b000010;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] ADDI  = 6'b001000;
    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;

    localparam int OP_MSB      = 31;
    localparam int OP_LSB      = 26;
    localparam int FUNCT_MSB   = 5;
    localparam int FUNCT_LSB   = 0;
    localparam int IMM_WIDTH   = 16;
    localparam int JADDR_WIDTH = 26;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        RESET_S = 2'd0,
        REQ_S   = 2'd1,
        WAIT_S  = 2'd2,
        HOLD_S  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_pc_next_calc.sv
// Next-PC selection for the fetch stage: jump > taken branch > pc+4.
// Ports: pc_plus4, instr, branch, alu_zero, jump in; next_pc out.
module pc_next_calc
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_WIDTH_P = 32,
    parameter int DATA_WIDTH_P = 32
) (
    input  logic [ADDR_WIDTH_P-1:0] pc_plus4,
    input  logic [DATA_WIDTH_P-1:0] instr,
    input  logic                    branch,
    input  logic                    alu_zero,
    input  logic                    jump,
    output logic [ADDR_WIDTH_P-1:0] next_pc
);

    logic [ADDR_WIDTH_P-1:0] jump_target;
    logic [ADDR_WIDTH_P-1:0] branch_offset;
    logic [ADDR_WIDTH_P-1:0] branch_target;
    logic                    unused;

    // Opcode bits never feed the address math.
    assign unused = ^instr[DATA_WIDTH_P-1:JADDR_WIDTH];

    assign jump_target = {pc_plus4[ADDR_WIDTH_P-1:JADDR_WIDTH+2],
                          instr[JADDR_WIDTH-1:0], 2'b00};

    assign branch_offset = {{(ADDR_WIDTH_P-IMM_WIDTH-2){instr[IMM_WIDTH-1]}},
                            instr[IMM_WIDTH-1:0], 2'b00};

    assign branch_target = pc_plus4 + branch_offset;

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch && alu_zero) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch stage feeding decode.
// Ports: clk/rst, imem request (valid/ready/addr), imem response
// (valid/data), decode handshake (valid/ready/instr + fields,
// pc_plus4) and redirect inputs (branch, alu_zero, jump).
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH_P  = 32,
    parameter int                    DATA_WIDTH_P  = 32,
    parameter logic [ADDR_WIDTH_P-1:0] RESET_PC_P  = ADDR_WIDTH_P'(RESET_PC),
    parameter int                    OP_WIDTH_P    = 6,
    parameter int                    FUNCT_WIDTH_P = 6
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    output logic                     o_imem_req_valid,
    input  logic                     i_imem_req_ready,
    output logic [ADDR_WIDTH_P-1:0]  o_imem_addr,
    input  logic                     i_imem_rsp_valid,
    input  logic [DATA_WIDTH_P-1:0]  i_imem_rsp_data,
    output logic                     o_instr_valid,
    input  logic                     i_instr_ready,
    output logic [DATA_WIDTH_P-1:0]  o_instr,
    output logic [OP_WIDTH_P-1:0]    o_opcode,
    output logic [FUNCT_WIDTH_P-1:0] o_function,
    output logic [ADDR_WIDTH_P-1:0]  o_pc_plus4,
    input  logic                     i_branch,
    input  logic                     i_alu_zero,
    input  logic                     i_jump
);

    fetch_state_t            state;
    fetch_state_t            state_next;
    logic [ADDR_WIDTH_P-1:0] pc;
    logic [ADDR_WIDTH_P-1:0] pc_plus4;
    logic [ADDR_WIDTH_P-1:0] next_pc;
    logic [DATA_WIDTH_P-1:0] instr;
    logic                    load_instr;
    logic                    load_pc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= RESET_S;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        o_imem_req_valid = 1'b0;
        load_instr       = 1'b0;
        load_pc          = 1'b0;
        unique case (state)
            RESET_S: state_next = REQ_S;
            REQ_S: begin
                o_imem_req_valid = 1'b1;
                if (i_imem_req_ready) begin
                    state_next = WAIT_S;
                end
            end
            WAIT_S: begin
                if (i_imem_rsp_valid) begin
                    load_instr = 1'b1;
                    state_next = HOLD_S;
                end
            end
            HOLD_S: begin
                if (i_instr_ready) begin
                    load_pc    = 1'b1;
                    state_next = REQ_S;
                end
            end
            default: state_next = RESET_S;
        endcase
    end

    // Reset PC is forced word-aligned so every later target is too.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc    <= RESET_PC_P & ~ADDR_WIDTH_P'(3);
            instr <= '0;
        end else begin
            if (load_instr) begin
                instr <= i_imem_rsp_data;
            end
            if (load_pc) begin
                pc <= next_pc;
            end
        end
    end

    assign pc_plus4 = pc + ADDR_WIDTH_P'(4);

    pc_next_calc #(
        .ADDR_WIDTH_P (ADDR_WIDTH_P),
        .DATA_WIDTH_P (DATA_WIDTH_P)
    ) u_pc_next_calc (
        .pc_plus4 (pc_plus4),
        .instr    (instr),
        .branch   (i_branch),
        .alu_zero (i_alu_zero),
        .jump     (i_jump),
        .next_pc  (next_pc)
    );

    assign o_imem_addr   = pc;
    assign o_instr_valid = (state == HOLD_S);
    assign o_instr       = instr;
    assign o_opcode      = instr[DATA_WIDTH_P-1 -: OP_WIDTH_P];
    assign o_function    = instr[FUNCT_WIDTH_P-1:0];
    assign o_pc_plus4    = pc_plus4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: redirects, stalls, reset
// abort and PC wrap, all checked against hand-computed values.
module tb_instr_fetch_unit;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready = 1'b0;
    logic [31:0] o_imem_addr;
    logic        i_imem_rsp_valid = 1'b0;
    logic [31:0] i_imem_rsp_data = '0;
    logic        o_instr_valid;
    logic        i_instr_ready = 1'b0;
    logic [31:0] o_instr;
    logic [5:0]  o_opcode;
    logic [5:0]  o_function;
    logic [31:0] o_pc_plus4;
    logic        i_branch = 1'b0;
    logic        i_alu_zero = 1'b0;
    logic        i_jump = 1'b0;

    int total = 0;
    int bad   = 0;

    instr_fetch_unit dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .o_imem_req_valid (o_imem_req_valid),
        .i_imem_req_ready (i_imem_req_ready),
        .o_imem_addr      (o_imem_addr),
        .i_imem_rsp_valid (i_imem_rsp_valid),
        .i_imem_rsp_data  (i_imem_rsp_data),
        .o_instr_valid    (o_instr_valid),
        .i_instr_ready    (i_instr_ready),
        .o_instr          (o_instr),
        .o_opcode         (o_opcode),
        .o_function       (o_function),
        .o_pc_plus4       (o_pc_plus4),
        .i_branch         (i_branch),
        .i_alu_zero       (i_alu_zero),
        .i_jump           (i_jump)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_req();
        for (int k = 0; k < 20 && !o_imem_req_valid; k++) @(negedge i_clk);
        check("req_seen", {31'd0, o_imem_req_valid}, 32'd1);
    endtask

    // One full fetch: request (optionally stalled), 1-cycle response,
    // hold (optionally stalled), then accept with the given redirect.
    task automatic fetch(input string tag, input logic [31:0] addr,
                         input logic [31:0] data, input logic br,
                         input logic z, input logic j,
                         input logic [31:0] exp_next,
                         input int req_stall, input int hold_stall);
        wait_req();
        check({tag, "_addr"}, o_imem_addr, addr);
        for (int k = 0; k < req_stall; k++) begin
            i_imem_req_ready = 1'b0;
            @(negedge i_clk);
            check({tag, "_stall_addr"}, o_imem_addr, addr);
            check({tag, "_stall_rv"}, {31'd0, o_imem_req_valid}, 32'd1);
        end
        i_imem_req_ready = 1'b1;
        @(negedge i_clk);
        i_imem_req_ready = 1'b0;
        check({tag, "_wait_rv"}, {31'd0, o_imem_req_valid}, 32'd0);
        check({tag, "_wait_iv"}, {31'd0, o_instr_valid}, 32'd0);
        i_imem_rsp_valid = 1'b1;
        i_imem_rsp_data  = data;
        @(negedge i_clk);
        i_imem_rsp_valid = 1'b0;
        i_imem_rsp_data  = 32'hDEAD_BEEF;
        check({tag, "_iv"}, {31'd0, o_instr_valid}, 32'd1);
        check({tag, "_instr"}, o_instr, data);
        check({tag, "_op"}, {26'd0, o_opcode}, {26'd0, data[31:26]});
        check({tag, "_fn"}, {26'd0, o_function}, {26'd0, data[5:0]});
        check({tag, "_pc4"}, o_pc_plus4, addr + 32'd4);
        for (int k = 0; k < hold_stall; k++) begin
            i_jump           = 1'b1;
            i_imem_rsp_valid = 1'b1;
            @(negedge i_clk);
            check({tag, "_hold_iv"}, {31'd0, o_instr_valid}, 32'd1);
            check({tag, "_hold_instr"}, o_instr, data);
            check({tag, "_hold_rv"}, {31'd0, o_imem_req_valid}, 32'd0);
        end
        i_imem_rsp_valid = 1'b0;
        i_instr_ready    = 1'b1;
        i_branch         = br;
        i_alu_zero       = z;
        i_jump           = j;
        @(negedge i_clk);
        i_instr_ready = 1'b0;
        i_branch      = 1'b0;
        i_alu_zero    = 1'b0;
        i_jump        = 1'b0;
        check({tag, "_acc_iv"}, {31'd0, o_instr_valid}, 32'd0);
        check({tag, "_acc_rv"}, {31'd0, o_imem_req_valid}, 32'd1);
        check({tag, "_next"}, o_imem_addr, exp_next);
    endtask

    initial begin
        repeat (3) @(negedge i_clk);
        check("rst_rv", {31'd0, o_imem_req_valid}, 32'd0);
        check("rst_iv", {31'd0, o_instr_valid}, 32'd0);
        check("rst_instr", o_instr, 32'd0);
        check("rst_addr", o_imem_addr, 32'd0);
        i_rst = 1'b0;

        fetch("addi", 32'h0, 32'h2008_0005, 0, 0, 0, 32'h4, 0, 0);
        check("addi_opc", {26'd0, dut.o_opcode}, 32'h08);
        fetch("nop4", 32'h4, 32'h0000_0020, 0, 0, 0, 32'h8, 0, 0);
        fetch("beq_t", 32'h8, 32'h1000_FFFF, 1, 1, 0, 32'h8, 0, 0);
        fetch("beq_nt", 32'h8, 32'h1000_FFFF, 1, 0, 0, 32'hC, 0, 0);
        fetch("j_far", 32'hC, 32'h0BFF_FFFF, 0, 0, 1,
              32'h0FFF_FFFC, 0, 0);
        fetch("nop_x", 32'h0FFF_FFFC, 32'h0000_0020, 0, 0, 0,
              32'h1000_0000, 0, 0);
        fetch("j_pri", 32'h1000_0000, 32'h0800_0010, 1, 1, 1,
              32'h1000_0040, 5, 4);

        // Reset while waiting, with a response landing the same cycle.
        wait_req();
        check("abort_addr", o_imem_addr, 32'h1000_0040);
        i_imem_req_ready = 1'b1;
        @(negedge i_clk);
        i_imem_req_ready = 1'b0;
        i_rst            = 1'b1;
        i_imem_rsp_valid = 1'b1;
        i_imem_rsp_data  = 32'h1234_5678;
        @(negedge i_clk);
        i_rst            = 1'b0;
        i_imem_rsp_valid = 1'b0;
        check("abort_iv", {31'd0, o_instr_valid}, 32'd0);
        check("abort_instr", o_instr, 32'd0);
        check("abort_rv", {31'd0, o_imem_req_valid}, 32'd0);
        @(negedge i_clk);
        check("abort_iv2", {31'd0, o_instr_valid}, 32'd0);

        fetch("beq_neg", 32'h0, 32'h1000_FFFE, 1, 1, 0,
              32'hFFFF_FFFC, 0, 0);
        fetch("wrap", 32'hFFFF_FFFC, 32'h0000_0020, 0, 0, 0,
              32'h0, 0, 0);
        check("wrap_align", {30'd0, o_imem_addr[1:0]}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
